// File: rtl/seg_scan_bcd.sv
// Multiplexed seven-segment controller: a sequential double-dabble converter
// feeds a PWM-dimmed digit scanner with leading-zero blanking and overflow glyph.
`timescale 1ns/1ps
module seg_scan_bcd #(
  parameter int DATA_W      = 16,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 262144
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic [DATA_W-1:0] value,
  input  logic              load,
  output logic              busy,
  input  logic              blank_lz,
  input  logic              err,
  input  logic [3:0]        bright,
  output logic [DIGITS-1:0] Anode_Activate,
  output logic [6:0]        LED_out
);
  localparam int CONV_D = (DATA_W * 302) / 1000 + 1;
  localparam int BCD_W  = 4 * CONV_D;
  localparam int SR_W   = BCD_W + DATA_W;
  localparam int DISP_W = 4 * DIGITS;
  localparam int PAD_W  = (CONV_D > DIGITS) ? BCD_W : DISP_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [6:0] GLYPH_E    = 7'b0110000;
  localparam logic [6:0] GLYPH_DASH = 7'b1111110;
  localparam logic [6:0] GLYPH_OFF  = 7'b1111111;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d, adj_sr;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic                ovf_q, ovf_d;
  logic [PAD_W-1:0]    bcd_pad;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    digit_q, digit_d;
  logic [3:0]          pwm_q;
  logic [DIGITS-1:0]   anode_q, anode_d, lz_run;
  logic [6:0]          led_q, led_d, glyph;
  logic [3:0]          cur_nib;
  logic                zero_run, pwm_on;

  function automatic logic [6:0] bcd_seg(input logic [3:0] n);
    case (n)
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b0000001;
    endcase
  endfunction

  assign bcd_pad = PAD_W'(sr_q[SR_W-1:DATA_W]);
  assign busy    = (state_q != IDLE);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    adj_sr  = sr_q;
    case (state_q)
      IDLE: if (load) begin
        sr_d    = {{BCD_W{1'b0}}, value};
        cnt_d   = CNT_W'(DATA_W);
        state_d = SHIFT;
      end
      SHIFT: begin
        for (int k = 0; k < CONV_D; k++)
          if (adj_sr[DATA_W+4*k +: 4] >= 4'd5)
            adj_sr[DATA_W+4*k +: 4] = adj_sr[DATA_W+4*k +: 4] + 4'd3;
        sr_d  = {adj_sr[SR_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = COMMIT;
      end
      COMMIT: begin
        // Display and overflow flag update together so no partial result is ever shown.
        disp_d  = bcd_pad[DISP_W-1:0];
        ovf_d   = |(bcd_pad >> DISP_W);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    digit_d = digit_q;
    if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      digit_d = (digit_q == IDX_W'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end

    // lz_run[i] is set when digit i and every more significant digit are zero.
    zero_run = 1'b1;
    lz_run   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run & (disp_q[4*i +: 4] == 4'd0);
      lz_run[i] = zero_run;
    end

    cur_nib = disp_q[4*digit_q +: 4];
    if (err)                                          glyph = GLYPH_E;
    else if (ovf_q)                                   glyph = GLYPH_DASH;
    else if (blank_lz && digit_q != '0 && lz_run[digit_q]) glyph = GLYPH_OFF;
    else                                              glyph = bcd_seg(cur_nib);

    pwm_on  = (bright == 4'hF) || (pwm_q < bright);
    anode_d = pwm_on ? ~(DIGITS'(1) << digit_q) : '1;
    led_d   = pwm_on ? glyph : GLYPH_OFF;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      digit_q <= '0;
      pwm_q   <= '0;
      anode_q <= '1;
      led_q   <= GLYPH_OFF;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      pwm_q   <= pwm_q + 1'b1;
      anode_q <= anode_d;
      led_q   <= led_d;
    end
  end

  assign Anode_Activate = anode_q;
  assign LED_out        = led_q;

endmodule

// File: tb/tb_seg_scan_bcd.sv
// Directed bench for seg_scan_bcd: table of conversions plus hand-written
// sequences for err, ignored loads, PWM brightness and mid-conversion reset.
`timescale 1ns/1ps
module tb_seg_scan_bcd;
  localparam int DATA_W      = 16;
  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010,
                         G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100,
                         G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000,
                         G9 = 7'b0000100, GE = 7'b0110000, GD = 7'b1111110,
                         GB = 7'b1111111;

  logic              clock_100Mhz = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] value = '0;
  logic              load = 1'b0;
  logic              busy;
  logic              blank_lz = 1'b0;
  logic              err = 1'b0;
  logic [3:0]        bright = 4'hF;
  logic [DIGITS-1:0] Anode_Activate;
  logic [6:0]        LED_out;

  int tests = 0;
  int fails = 0;
  int multi_low = 0;

  logic [6:0] seen [DIGITS];
  logic [DIGITS-1:0] seen_v;

  typedef struct packed {
    logic [15:0] val;
    logic        blz;
    logic [27:0] exp;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  vec_t vecs [9];

  seg_scan_bcd #(.DATA_W(DATA_W), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clock_100Mhz  (clock_100Mhz),
    .reset         (reset),
    .value         (value),
    .load          (load),
    .busy          (busy),
    .blank_lz      (blank_lz),
    .err           (err),
    .bright        (bright),
    .Anode_Activate(Anode_Activate),
    .LED_out       (LED_out)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Watch the scan for ncyc cycles and record the glyph seen on each digit.
  task automatic capture(input int ncyc);
    seen_v = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock_100Mhz);
      case (Anode_Activate)
        4'b1110: begin seen[0] = LED_out; seen_v[0] = 1'b1; end
        4'b1101: begin seen[1] = LED_out; seen_v[1] = 1'b1; end
        4'b1011: begin seen[2] = LED_out; seen_v[2] = 1'b1; end
        4'b0111: begin seen[3] = LED_out; seen_v[3] = 1'b1; end
        4'b1111: ;
        default: multi_low++;
      endcase
    end
  endtask

  task automatic check_digits(input string tag, input logic [27:0] exp);
    for (int i = 0; i < DIGITS; i++)
      check($sformatf("%s digit%0d", tag, i), {24'd0, seen_v[i], seen[i]}, {24'd0, 1'b1, exp[7*i +: 7]});
  endtask

  // Pulses load for one cycle and returns how many cycles busy stayed high.
  task automatic do_load(input logic [15:0] v, output int bc);
    @(negedge clock_100Mhz);
    value = v;
    load  = 1'b1;
    @(negedge clock_100Mhz);
    load = 1'b0;
    bc   = 0;
    while (busy === 1'b1 && bc < 100) begin
      bc++;
      @(negedge clock_100Mhz);
    end
  endtask

  initial begin
    int bc, n, on;
    logic [DIGITS-1:0] a;

    vecs[0] = '{val: 16'd1234,  blz: 1'b0, exp: {G1, G2, G3, G4}};
    vecs[1] = '{val: 16'd65535, blz: 1'b0, exp: {GD, GD, GD, GD}};
    vecs[2] = '{val: 16'd7,     blz: 1'b1, exp: {GB, GB, GB, G7}};
    vecs[3] = '{val: 16'd0,     blz: 1'b1, exp: {GB, GB, GB, G0}};
    vecs[4] = '{val: 16'd9999,  blz: 1'b0, exp: {G9, G9, G9, G9}};
    vecs[5] = '{val: 16'd10000, blz: 1'b0, exp: {GD, GD, GD, GD}};
    vecs[6] = '{val: 16'd305,   blz: 1'b1, exp: {GB, G3, G0, G5}};
    vecs[7] = '{val: 16'd86,    blz: 1'b0, exp: {G0, G0, G8, G6}};
    vecs[8] = '{val: 16'd42,    blz: 1'b1, exp: {GB, GB, G4, G2}};

    repeat (3) @(negedge clock_100Mhz);
    check("reset anodes", 32'(Anode_Activate), 32'hF);
    check("reset led", 32'(LED_out), 32'h7F);
    check("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;

    capture(20);
    check_digits("after reset", {G0, G0, G0, G0});

    a = Anode_Activate;
    n = 0;
    while (Anode_Activate === a && n < 50) begin @(negedge clock_100Mhz); n++; end
    a = Anode_Activate;
    n = 0;
    while (Anode_Activate === a && n < 50) begin @(negedge clock_100Mhz); n++; end
    check("slot period", n, REFRESH_DIV);

    for (int v = 0; v < 9; v++) begin
      blank_lz = vecs[v].blz;
      do_load(vecs[v].val, bc);
      check($sformatf("vec%0d busy cycles", v), bc, DATA_W + 1);
      capture(20);
      check_digits($sformatf("vec%0d value %0d", v, vecs[v].val), vecs[v].exp);
    end

    // err mid-conversion, plus a second load while busy that must be ignored.
    blank_lz = 1'b0;
    @(negedge clock_100Mhz);
    value = 16'd42;
    load  = 1'b1;
    @(negedge clock_100Mhz);
    load = 1'b0;
    bc   = 0;
    while (busy === 1'b1 && bc < 100) begin
      if (bc == 3) err = 1'b1;
      if (bc == 4) check("err glyph one cycle later", 32'(LED_out), 32'(GE));
      if (bc == 5) begin value = 16'd9999; load = 1'b1; end
      if (bc == 6) load = 1'b0;
      bc++;
      @(negedge clock_100Mhz);
    end
    check("busy with ignored load", bc, DATA_W + 1);
    capture(20);
    check_digits("err shown", {GE, GE, GE, GE});
    err = 1'b0;
    @(negedge clock_100Mhz);
    capture(20);
    check_digits("after err 0042", {G0, G0, G4, G2});

    bright = 4'd4;
    repeat (2) @(negedge clock_100Mhz);
    for (int w = 0; w < 2; w++) begin
      on = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge clock_100Mhz);
        if (Anode_Activate !== 4'hF) on++;
      end
      check($sformatf("bright4 window%0d", w), on, 4);
    end
    bright = 4'd0;
    repeat (2) @(negedge clock_100Mhz);
    on = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clock_100Mhz);
      if (Anode_Activate !== 4'hF) on++;
    end
    check("bright0 anodes off", on, 0);
    bright = 4'hF;

    @(negedge clock_100Mhz);
    value = 16'd1234;
    load  = 1'b1;
    @(negedge clock_100Mhz);
    load = 1'b0;
    repeat (7) @(negedge clock_100Mhz);
    check("busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset anodes", 32'(Anode_Activate), 32'hF);
    check("mid reset led", 32'(LED_out), 32'h7F);
    @(negedge clock_100Mhz);
    reset = 1'b0;
    capture(20);
    check_digits("after mid reset", {G0, G0, G0, G0});
    check("busy stays low after reset", 32'(busy), 32'd0);

    check("single anode low", multi_low, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
